mem_access_ctrl: RTL and testbench

- Sequences MEM-stage data-memory accesses against a variable-latency data memory using a req/ack handshake.
- While an access is outstanding, freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) and forces a bubble into MEM/WB.
- Releases the pipeline for exactly one cycle when the access completes, so MEM/WB captures the load/store result.
- Sits beside the MEM stage, between the EX/MEM register outputs and the MEM/WB register inputs.

---
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Runs a req/ack handshake against a variable-latency data memory. While an
// access is outstanding it freezes the upstream pipeline and bubbles MEM/WB.
// When the access completes it releases the pipeline for exactly one cycle.
// If no ack arrives within TIMEOUT access cycles it parks in a sticky error state.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [31:0] MEM_Address,
    input  logic [31:0] MEM_WriteData,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] MEM_ReadData,
    output logic        stall,
    output logic        wb_bubble,
    output logic        mem_error
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StError
    } stateT;

    stateT             stateQ, stateD;
    logic              reqQ;
    logic              weQ;
    logic [31:0]       addrQ;
    logic [31:0]       wdataQ;
    logic [31:0]       rdataQ;
    logic [CNT_W-1:0]  cntQ;
    logic              errQ;

    logic              memOp;
    logic              timeoutHit;

    assign memOp      = MEM_MemRead | MEM_MemWrite;
    // cntQ counts ACCESS cycles already spent without an ack, starting at 0.
    assign timeoutHit = (cntQ == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state decode; an ack always beats a coincident timeout.
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (memOp) begin
                    stateD = StAccess;
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    stateD = StDone;
                end else if (timeoutHit) begin
                    stateD = StError;
                end
            end
            // The op still visible here has just completed, so never re-arm from DONE.
            StDone:  stateD = StIdle;
            StError: stateD = StError;
        endcase
    end

    // Pipeline control outputs.
    always_comb begin
        stall     = 1'b0;
        wb_bubble = 1'b0;
        unique case (stateQ)
            StIdle: begin
                // Freeze in the detect cycle so EX/MEM holds the op while it is latched.
                stall     = memOp;
                wb_bubble = memOp;
            end
            StAccess, StError: begin
                stall     = 1'b1;
                wb_bubble = 1'b1;
            end
            StDone: begin
                stall     = 1'b0;
                wb_bubble = 1'b0;
            end
        endcase
        if (reset) begin
            stall     = 1'b0;
            wb_bubble = 1'b0;
        end
    end

    // Request, latched access fields, wait counter, load data and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqQ   <= 1'b0;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
            rdataQ <= '0;
            cntQ   <= '0;
            errQ   <= 1'b0;
        end else if (stateQ == StIdle) begin
            if (memOp) begin
                reqQ   <= 1'b1;
                // Read wins when both strobes are set.
                weQ    <= MEM_MemWrite & ~MEM_MemRead;
                addrQ  <= MEM_Address;
                wdataQ <= MEM_WriteData;
                cntQ   <= '0;
            end
        end else if (stateQ == StAccess) begin
            if (dmem_ack) begin
                reqQ <= 1'b0;
                if (!weQ) begin
                    rdataQ <= dmem_rdata;
                end
            end else begin
                cntQ <= cntQ + CNT_W'(1);
                if (timeoutHit) begin
                    reqQ <= 1'b0;
                    errQ <= 1'b1;
                end
            end
        end
    end

    assign dmem_req     = reqQ;
    assign dmem_we      = weQ;
    assign dmem_addr    = addrQ;
    assign dmem_wdata   = wdataQ;
    assign MEM_ReadData = rdataQ;
    assign mem_error    = errQ;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl.
// The reference model works per transaction: an op acked in ACCESS cycle k
// gives one detect cycle plus k request cycles, then one release cycle; no ack
// within TIMEOUT cycles gives a sticky error.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 5;

    logic        clk;
    logic        reset;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_WriteData;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] MEM_ReadData;
    logic        stall;
    logic        wb_bubble;
    logic        mem_error;

    int errCnt = 0;
    int chkCnt = 0;

    // Model: last loaded value as the pipeline should see it.
    logic [31:0] expReadData;

    mem_access_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_Address  (MEM_Address),
        .MEM_WriteData(MEM_WriteData),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .MEM_ReadData (MEM_ReadData),
        .stall        (stall),
        .wb_bubble    (wb_bubble),
        .mem_error    (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Move to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset        = 1'b1;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        dmem_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        expReadData = '0;
        #1;
        checkEq("rst_stall", stall, 0);
        checkEq("rst_bubble", wb_bubble, 0);
        checkEq("rst_req", dmem_req, 0);
        checkEq("rst_we", dmem_we, 0);
        checkEq("rst_addr", dmem_addr, 0);
        checkEq("rst_wdata", dmem_wdata, 0);
        checkEq("rst_rdata", MEM_ReadData, 0);
        checkEq("rst_err", mem_error, 0);
    endtask

    // Cycles with no memory op; stray acks must be ignored.
    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            MEM_MemRead  = 1'b0;
            MEM_MemWrite = 1'b0;
            dmem_ack     = 1'($urandom % 2);
            dmem_rdata   = $urandom;
            #1;
            checkEq("idle_stall", stall, 0);
            checkEq("idle_bubble", wb_bubble, 0);
            checkEq("idle_req", dmem_req, 0);
            checkEq("idle_rdata", MEM_ReadData, expReadData);
        end
    endtask

    // One memory op; ackAt in 1..TIMEOUT is the ACCESS cycle that acks, 0 means never.
    task automatic doAccess(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ackAt,
                            input logic [31:0] ackData);
        logic expWe;
        expWe = wr & ~rd;
        // Detect cycle.
        nextCycle();
        MEM_MemRead   = rd;
        MEM_MemWrite  = wr;
        MEM_Address   = addr;
        MEM_WriteData = wdata;
        dmem_ack      = 1'($urandom % 2);
        dmem_rdata    = $urandom;
        #1;
        checkEq("det_stall", stall, 1);
        checkEq("det_bubble", wb_bubble, 1);
        checkEq("det_req", dmem_req, 0);
        checkEq("det_rdata", MEM_ReadData, expReadData);
        // Request cycles; the raw inputs wander to prove the request is latched.
        for (int j = 1; j <= int'(TIMEOUT); j++) begin
            nextCycle();
            MEM_Address   = $urandom;
            MEM_WriteData = $urandom;
            dmem_ack      = (j == ackAt);
            dmem_rdata    = (j == ackAt) ? ackData : $urandom;
            #1;
            checkEq("acc_req", dmem_req, 1);
            checkEq("acc_stall", stall, 1);
            checkEq("acc_bubble", wb_bubble, 1);
            checkEq("acc_we", dmem_we, 32'(expWe));
            checkEq("acc_addr", dmem_addr, addr);
            checkEq("acc_wdata", dmem_wdata, wdata);
            checkEq("acc_err", mem_error, 0);
            checkEq("acc_rdata", MEM_ReadData, expReadData);
            if (j == ackAt) begin
                if (!expWe) expReadData = ackData;
                break;
            end
        end
        if (ackAt == 0) begin
            // Error state: frozen until reset, late acks ignored.
            for (int i = 0; i < 24; i++) begin
                nextCycle();
                dmem_ack   = 1'($urandom % 2);
                dmem_rdata = $urandom;
                #1;
                checkEq("err_flag", mem_error, 1);
                checkEq("err_req", dmem_req, 0);
                checkEq("err_stall", stall, 1);
                checkEq("err_bubble", wb_bubble, 1);
                checkEq("err_rdata", MEM_ReadData, expReadData);
            end
        end else begin
            // Release cycle; the completed op may still be visible and must not re-arm.
            nextCycle();
            dmem_ack     = 1'($urandom % 2);
            dmem_rdata   = $urandom;
            MEM_MemRead  = 1'($urandom % 2);
            MEM_MemWrite = 1'($urandom % 2);
            #1;
            checkEq("done_stall", stall, 0);
            checkEq("done_bubble", wb_bubble, 0);
            checkEq("done_req", dmem_req, 0);
            checkEq("done_rdata", MEM_ReadData, expReadData);
            checkEq("done_err", mem_error, 0);
            checkEq("done_we", dmem_we, 32'(expWe));
        end
    endtask

    // Reset lands in the second ACCESS cycle together with an ack that must be dropped.
    task automatic doResetMidAccess();
        nextCycle();
        MEM_MemRead   = 1'b1;
        MEM_MemWrite  = 1'b0;
        MEM_Address   = 32'h0000_0100;
        MEM_WriteData = $urandom;
        dmem_ack      = 1'b0;
        nextCycle();
        dmem_ack = 1'b0;
        #1;
        checkEq("mid_req1", dmem_req, 1);
        nextCycle();
        reset      = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hBAD0_BAD0;
        nextCycle();
        reset        = 1'b0;
        dmem_ack     = 1'b0;
        MEM_MemRead  = 1'b0;
        MEM_MemWrite = 1'b0;
        expReadData  = '0;
        #1;
        checkEq("mid_req", dmem_req, 0);
        checkEq("mid_stall", stall, 0);
        checkEq("mid_bubble", wb_bubble, 0);
        checkEq("mid_rdata", MEM_ReadData, 0);
        checkEq("mid_err", mem_error, 0);
    endtask

    initial begin
        reset         = 1'b1;
        MEM_MemRead   = 1'b0;
        MEM_MemWrite  = 1'b0;
        MEM_Address   = '0;
        MEM_WriteData = '0;
        dmem_ack      = 1'b0;
        dmem_rdata    = '0;
        expReadData   = '0;

        doReset();

        // Load acked in the first ACCESS cycle.
        doAccess(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hDEAD_BEEF);
        runIdle(1);
        // Store acked in the third ACCESS cycle.
        doAccess(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 3, $urandom);
        // Back-to-back loads, each acked in two cycles.
        doAccess(1'b1, 1'b0, 32'h0000_0200, $urandom, 2, 32'hA5A5_0001);
        doAccess(1'b1, 1'b0, 32'h0000_0204, $urandom, 2, 32'h5A5A_0002);
        // Ack in the same cycle the timeout would fire.
        doAccess(1'b1, 1'b0, 32'h0000_0300, $urandom, int'(TIMEOUT), 32'hC0DE_0016);
        // Both strobes set: treated as a load.
        doAccess(1'b1, 1'b1, 32'h0000_0400, $urandom, 2, 32'h0B07_0003);

        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = $urandom_range(0, 2);
            doAccess(sel != 1, sel != 0, $urandom, $urandom,
                     int'($urandom_range(1, TIMEOUT)), $urandom);
            runIdle(int'($urandom_range(0, 2)));
        end

        doResetMidAccess();
        doAccess(1'b1, 1'b0, 32'h0000_0104, $urandom, 2, 32'h7777_8888);
        runIdle(1);

        // No ack at all: sticky error, then reset clears it.
        doAccess(1'b0, 1'b1, 32'h0000_0500, 32'hFEED_F00D, 0, 32'h0);
        doReset();
        doAccess(1'b1, 1'b0, 32'h0000_0600, $urandom, 1, 32'h1357_9BDF);

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
